// File: rtl/mcp_reg_sequencer.sv
// Purpose : arbitrate NREQ requesters onto one multicycle-path destination register,
//           holding mcp_val stable for SETTLE cycles before a single-cycle mcp_set strobe.
// Latency : req seen in IDLE cycle 0 -> SETTLE cycles 1..SETTLE -> mcp_set/ack in cycle SETTLE+1.
// Backpressure: level-sensitive requests simply wait while busy; none are dropped.
//
// Ports:
//   CLK, RST   clock, synchronous active-high reset
//   req        per-requester level request, held through its ack cycle
//   req_data   requester i data at [i*WIDTH +: WIDTH], sampled only on the grant cycle
//   ack        one-hot single-cycle pulse in the commit cycle
//   busy       high while a transfer is settling or committing
//   grant_id   index of the current / most recently granted requester
//   mcp_val    held data feeding the MCP register's val input
//   mcp_set    single-cycle load strobe feeding the MCP register's SET input
//
// Build option: define MCP_SEQ_RR_EN for round-robin arbitration; otherwise
// fixed priority with the lowest index winning.

module mcp_reg_sequencer #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 32,
    parameter int SETTLE = 3
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           ack,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic [WIDTH-1:0]          mcp_val,
    output logic                      mcp_set
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hold;

    // Arbitration result for the current cycle; only consumed in IDLE.
    logic             win_vld;
    logic [IDW-1:0]   win_id;

`ifdef MCP_SEQ_RR_EN
    // Pointer to the last granted requester; the search starts just past it.
    // Resetting to NREQ-1 makes requester 0 the first candidate.
    logic [IDW-1:0]   rr_ptr;

    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        // Walk from the farthest candidate back to the nearest so the
        // nearest asserted request after the pointer is the final assignment.
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(rr_ptr) + k) % NREQ]) begin
                win_vld = 1'b1;
                win_id  = IDW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr <= IDW'(NREQ - 1);
        end else if (state == S_IDLE && win_vld) begin
            rr_ptr <= win_id;
        end
    end
`else
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        // Descending scan: the lowest asserted index is written last and wins.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_vld = 1'b1;
                win_id  = IDW'(i);
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers: hold data, grant index, settle counter.
    // hold only loads on the IDLE->SETTLE edge, so req_data changes after
    // the grant never reach mcp_val, and the last committed value persists.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            hold     <= '0;
            grant_id <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_vld) begin
                        hold     <= req_data[win_id*WIDTH +: WIDTH];
                        grant_id <= win_id;
                        cnt      <= CW'(SETTLE - 1);
                    end
                end
                S_SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (win_vld) begin
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state and registers only, never from req,
    // so the MCP register's inputs see no combinational path from clients.
    // ------------------------------------------------------------------
    always_comb begin
        busy    = 1'b0;
        mcp_set = 1'b0;
        ack     = '0;
        case (state)
            S_SETTLE: begin
                busy = 1'b1;
            end
            S_COMMIT: begin
                busy          = 1'b1;
                mcp_set       = 1'b1;
                ack[grant_id] = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign mcp_val = hold;

endmodule

// File: tb/tb_mcp_reg_sequencer.sv
module tb_mcp_reg_sequencer;

    localparam int NREQ   = 4;
    localparam int WIDTH  = 32;
    localparam int SETTLE = 3;
    localparam int IDW    = $clog2(NREQ);

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Main instance, SETTLE = 3
    logic                  RST;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       ack;
    logic                  busy;
    logic [IDW-1:0]        grant_id;
    logic [WIDTH-1:0]      mcp_val;
    logic                  mcp_set;

    // Second instance, SETTLE = 1
    logic                  rst1;
    logic [NREQ-1:0]       req1;
    logic [NREQ*WIDTH-1:0] req_data1;
    logic [NREQ-1:0]       ack1;
    logic                  busy1;
    logic [IDW-1:0]        grant_id1;
    logic [WIDTH-1:0]      mcp_val1;
    logic                  mcp_set1;

    mcp_reg_sequencer #(.NREQ(NREQ), .WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .CLK(CLK), .RST(RST), .req(req), .req_data(req_data),
        .ack(ack), .busy(busy), .grant_id(grant_id), .mcp_val(mcp_val), .mcp_set(mcp_set)
    );

    mcp_reg_sequencer #(.NREQ(NREQ), .WIDTH(WIDTH), .SETTLE(1)) dut_s1 (
        .CLK(CLK), .RST(rst1), .req(req1), .req_data(req_data1),
        .ack(ack1), .busy(busy1), .grant_id(grant_id1), .mcp_val(mcp_val1), .mcp_set(mcp_set1)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input int idx, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0d: got 0x%0h expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    // Directed table: inputs applied in a cycle and outputs expected in that same cycle.
    typedef struct {
        logic             rst;
        logic [NREQ-1:0]  rq;
        logic [WIDTH-1:0] d0;
        logic [WIDTH-1:0] d2;
        logic [NREQ-1:0]  e_ack;
        logic             e_busy;
        logic             e_set;
        logic [IDW-1:0]   e_gid;
        logic [WIDTH-1:0] e_val;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [NREQ-1:0] q, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [NREQ-1:0] ea, input logic eb,
                       input logic es, input logic [IDW-1:0] eg, input logic [WIDTH-1:0] ev);
        vec_t v;
        v.rst = r; v.rq = q; v.d0 = a; v.d2 = b;
        v.e_ack = ea; v.e_busy = eb; v.e_set = es; v.e_gid = eg; v.e_val = ev;
        tbl.push_back(v);
    endtask

    // Reference model: the sequencer is described by the cycle of the last grant.
    // A grant in cycle g makes cycles g+1..g+SETTLE+1 busy and strobes in g+SETTLE+1.
    int               m_g;
    logic [IDW-1:0]   m_gid;
    logic [WIDTH-1:0] m_hold;
    int               m_ptr;

    function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
`ifdef MCP_SEQ_RR_EN
        for (int k = 1; k <= NREQ; k++)
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
`else
        for (int i = 0; i < NREQ; i++)
            if (r[i]) return i + 0 * ptr;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_g    = -100;
        m_gid  = '0;
        m_hold = '0;
        m_ptr  = NREQ - 1;
    endtask

    initial begin
        logic [NREQ-1:0]  r;
        logic [NREQ-1:0]  cool;
        logic [NREQ-1:0]  e_ack;
        logic [NREQ-1:0]  last_ack;
        logic [NREQ-1:0]  onehot;
        logic             e_set;
        logic             inflight;
        logic             rst_v;
        int               w;
        int               nack;
        int               order [4];

        RST = 1'b1; req = '0; req_data = '0;
        rst1 = 1'b1; req1 = '0; req_data1 = '0;
        repeat (2) @(posedge CLK);
        #1;

        // ---------------- table-driven directed sequence ----------------
        //    rst  req      d0            d2            ack      busy set gid  val
        add(0, 4'b0001, 32'hDEADBEEF, 32'h0,        4'b0000, 0, 0, 2'd0, 32'h0);
        add(0, 4'b0001, 32'h12345678, 32'h0,        4'b0000, 1, 0, 2'd0, 32'hDEADBEEF);
        add(0, 4'b0001, 32'h12345678, 32'h0,        4'b0000, 1, 0, 2'd0, 32'hDEADBEEF);
        add(0, 4'b0001, 32'h12345678, 32'h0,        4'b0000, 1, 0, 2'd0, 32'hDEADBEEF);
        add(0, 4'b0001, 32'h12345678, 32'h0,        4'b0001, 1, 1, 2'd0, 32'hDEADBEEF);
        add(0, 4'b0000, 32'h12345678, 32'h0,        4'b0000, 0, 0, 2'd0, 32'hDEADBEEF);
        add(0, 4'b0101, 32'hA0A0A0A0, 32'hC2C2C2C2, 4'b0000, 0, 0, 2'd0, 32'hDEADBEEF);
        add(0, 4'b0101, 32'hA0A0A0A0, 32'hC2C2C2C2, 4'b0000, 1, 0, 2'd0, 32'hA0A0A0A0);
        add(0, 4'b0101, 32'hA0A0A0A0, 32'hC2C2C2C2, 4'b0000, 1, 0, 2'd0, 32'hA0A0A0A0);
        add(0, 4'b0101, 32'hA0A0A0A0, 32'hC2C2C2C2, 4'b0000, 1, 0, 2'd0, 32'hA0A0A0A0);
        add(0, 4'b0101, 32'hA0A0A0A0, 32'hC2C2C2C2, 4'b0001, 1, 1, 2'd0, 32'hA0A0A0A0);
        add(0, 4'b0100, 32'hA0A0A0A0, 32'hC2C2C2C2, 4'b0000, 0, 0, 2'd0, 32'hA0A0A0A0);
        add(0, 4'b0100, 32'hA0A0A0A0, 32'hC2C2C2C2, 4'b0000, 1, 0, 2'd2, 32'hC2C2C2C2);
        add(0, 4'b0100, 32'hA0A0A0A0, 32'hC2C2C2C2, 4'b0000, 1, 0, 2'd2, 32'hC2C2C2C2);
        add(0, 4'b0100, 32'hA0A0A0A0, 32'hC2C2C2C2, 4'b0000, 1, 0, 2'd2, 32'hC2C2C2C2);
        add(0, 4'b0100, 32'hA0A0A0A0, 32'hC2C2C2C2, 4'b0100, 1, 1, 2'd2, 32'hC2C2C2C2);
        add(0, 4'b0000, 32'hA0A0A0A0, 32'hC2C2C2C2, 4'b0000, 0, 0, 2'd2, 32'hC2C2C2C2);
        add(0, 4'b0100, 32'hA0A0A0A0, 32'h55AA55AA, 4'b0000, 0, 0, 2'd2, 32'hC2C2C2C2);
        add(0, 4'b0100, 32'hA0A0A0A0, 32'h55AA55AA, 4'b0000, 1, 0, 2'd2, 32'h55AA55AA);
        add(1, 4'b0100, 32'hA0A0A0A0, 32'h66666666, 4'b0000, 1, 0, 2'd2, 32'h55AA55AA);
        add(0, 4'b0100, 32'hA0A0A0A0, 32'h66666666, 4'b0000, 0, 0, 2'd0, 32'h0);
        add(0, 4'b0100, 32'hA0A0A0A0, 32'h66666666, 4'b0000, 1, 0, 2'd2, 32'h66666666);
        add(0, 4'b0100, 32'hA0A0A0A0, 32'h66666666, 4'b0000, 1, 0, 2'd2, 32'h66666666);
        add(0, 4'b0100, 32'hA0A0A0A0, 32'h66666666, 4'b0000, 1, 0, 2'd2, 32'h66666666);
        add(0, 4'b0100, 32'hA0A0A0A0, 32'h66666666, 4'b0100, 1, 1, 2'd2, 32'h66666666);
        add(0, 4'b0000, 32'hA0A0A0A0, 32'h66666666, 4'b0000, 0, 0, 2'd2, 32'h66666666);

        for (int i = 0; i < tbl.size(); i++) begin
            chk("tbl_ack",  i, WIDTH'(ack),      WIDTH'(tbl[i].e_ack));
            chk("tbl_busy", i, WIDTH'(busy),     WIDTH'(tbl[i].e_busy));
            chk("tbl_set",  i, WIDTH'(mcp_set),  WIDTH'(tbl[i].e_set));
            chk("tbl_gid",  i, WIDTH'(grant_id), WIDTH'(tbl[i].e_gid));
            chk("tbl_val",  i, mcp_val,          tbl[i].e_val);
            RST      = tbl[i].rst;
            req      = tbl[i].rq;
            req_data = '0;
            req_data[0*WIDTH +: WIDTH] = tbl[i].d0;
            req_data[2*WIDTH +: WIDTH] = tbl[i].d2;
            @(posedge CLK);
            #1;
        end

        // ---------------- two requesters held, each dropped one cycle after its ack ----------------
        RST = 1'b1; req = '0;
        @(posedge CLK); #1;
        RST = 1'b0;
        order[0] = 0; order[1] = 1; order[2] = 0; order[3] = 1;
        nack = 0;
        last_ack = '0;
        for (int k = 0; k < 24; k++) begin
            if (ack != '0) begin
                onehot = '0;
                if (nack < 4) onehot[order[nack]] = 1'b1;
                chk("alt_ack", nack, WIDTH'(ack), WIDTH'(onehot));
                nack++;
            end
            req      = 4'b0011 & ~last_ack;
            req_data = {$urandom, $urandom, $urandom, $urandom};
            last_ack = ack;
            @(posedge CLK); #1;
        end
        chk("alt_count", 0, WIDTH'(nack), WIDTH'(4));

        // ---------------- randomized traffic against the reference model ----------------
        RST = 1'b1; req = '0;
        @(posedge CLK); #1;
        model_reset();
        r = '0; cool = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            inflight = (cyc > m_g) && (cyc <= m_g + SETTLE + 1);
            e_set    = (cyc == m_g + SETTLE + 1);
            e_ack    = '0;
            if (e_set) e_ack[m_gid] = 1'b1;
            chk("rnd_ack",  cyc, WIDTH'(ack),      WIDTH'(e_ack));
            chk("rnd_busy", cyc, WIDTH'(busy),     WIDTH'(inflight));
            chk("rnd_set",  cyc, WIDTH'(mcp_set),  WIDTH'(e_set));
            chk("rnd_gid",  cyc, WIDTH'(grant_id), WIDTH'(m_gid));
            chk("rnd_val",  cyc, mcp_val,          m_hold);

            // Requester behaviour: hold through ack, drop for the next cycle,
            // with an occasional early drop to exercise the protocol-error path.
            for (int i = 0; i < NREQ; i++) begin
                if (cool[i]) begin
                    r[i] = 1'b0;
                    cool[i] = 1'b0;
                end else if (r[i]) begin
                    if (e_ack[i]) cool[i] = 1'b1;
                    else if ($urandom_range(0, 99) < 2) r[i] = 1'b0;
                end else if ($urandom_range(0, 99) < 30) begin
                    r[i] = 1'b1;
                end
            end
            rst_v    = ($urandom_range(0, 59) == 0);
            RST      = rst_v;
            req      = r;
            req_data = {$urandom, $urandom, $urandom, $urandom};

            if (rst_v) begin
                model_reset();
            end else if (!inflight && (r != '0)) begin
                w      = pick(r, m_ptr);
                m_g    = cyc;
                m_gid  = IDW'(w);
                m_hold = req_data[w*WIDTH +: WIDTH];
                m_ptr  = w;
            end
            @(posedge CLK); #1;
        end
        RST = 1'b0; req = '0;

        // ---------------- SETTLE = 1, requester 1 permanently asserted ----------------
        req1 = 4'b0010;
        @(posedge CLK); #1;
        rst1 = 1'b0;
        for (int k = 0; k < 30; k++) begin
            chk("s1_set",  k, WIDTH'(mcp_set1), WIDTH'((k % 3) == 2));
            chk("s1_ack",  k, WIDTH'(ack1),     ((k % 3) == 2) ? WIDTH'(4'b0010) : WIDTH'(0));
            chk("s1_busy", k, WIDTH'(busy1),    WIDTH'((k % 3) != 0));
            req_data1 = {$urandom, $urandom, $urandom, $urandom};
            @(posedge CLK); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
